counter_wrap_monitor: RTL and testbench

//  Downstream observer for the 4-bit loadable up-counter (ports MR/LOAD/EN/CLK/D/Q/CO).
//  - Taps the counter's LOAD, EN and Q, and predicts each 1111->0000 wrap on the edge it happens.
//  - Keeps a running wrap count.
//  - Measures the CLK-cycle period between consecutive wraps.
//  - Hands each period measurement to a consumer over a VALID/READY handshake.
//  - Needed because the counter's CO is sticky and only flags the first wrap.

---
 rtl/counter_wrap_monitor.sv | 144 ++++++++++++++
 tb/tb_counter_wrap_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/counter_wrap_monitor.sv
// counter_wrap_monitor
// Observer that sits beside a 4-bit loadable up-counter. It predicts every
// 1111->0000 wrap from the counter's own LOAD/EN/Q taps, keeps a running wrap
// count, times the distance between consecutive wraps and offers each period
// to a consumer over a VALID/READY handshake. The counter's own carry-out is
// sticky, so it cannot be used to see anything after the first wrap.

module counter_wrap_monitor #(
   parameter int W = 8,
   parameter int P = 12
) (
   input  logic         i_clk,
   input  logic         i_mr,
   input  logic         i_load,
   input  logic         i_en,
   input  logic [3:0]   i_q,
   input  logic         i_ready,
   output logic [W-1:0] o_wraps,
   output logic [P-1:0] o_period,
   output logic         o_psat,
   output logic         o_valid,
   output logic         o_overrun,
   output logic         o_armed
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } state_t;

   // Saturation ceiling for the period counter, held one bit wider so that
   // cnt+1 can be compared against it without overflowing.
   localparam logic [P:0] SAT_WIDE = {1'b0, {P{1'b1}}};

   state_t         r_state;
   state_t         w_stateNext;
   logic [P-1:0]   r_cnt;
   logic [P-1:0]   w_cntNext;
   logic [W-1:0]   r_wraps;
   logic [P-1:0]   r_period;
   logic           r_psat;
   logic           r_valid;
   logic           r_overrun;

   logic           w_wrapEvt;
   logic [P:0]     w_cntInc;
   logic           w_cntAtSat;
   logic [P-1:0]   w_cntSat;
   logic           w_capture;
   logic           w_handshake;

   // The counter wraps on exactly the edges where it is counting (not loading)
   // and already sits at its terminal value, so this mirrors its own next step.
   assign w_wrapEvt   = i_load & i_en & (i_q == 4'hF);

   // One-bit-wider increment lets a counter already pinned at the ceiling
   // still report "at or past saturation".
   assign w_cntInc    = {1'b0, r_cnt} + {{P{1'b0}}, 1'b1};
   assign w_cntAtSat  = (w_cntInc >= SAT_WIDE);
   assign w_cntSat    = w_cntAtSat ? SAT_WIDE[P-1:0] : w_cntInc[P-1:0];

   assign w_handshake = r_valid & i_ready;

   // Next-state and period-counter logic. A preset while armed abandons the
   // measurement in progress; a wrap while armed closes one and starts the next.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_capture   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_cntNext = '0;
            if (w_wrapEvt) begin
               w_stateNext = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (!i_load) begin
               w_stateNext = ST_IDLE;
               w_cntNext   = '0;
            end else if (w_wrapEvt) begin
               w_capture   = 1'b1;
               w_cntNext   = '0;
            end else begin
               w_cntNext   = w_cntSat;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
            w_cntNext   = '0;
         end
      endcase
   end

   // State and period-counter registers; MR overrides everything.
   always_ff @(posedge i_clk) begin
      if (i_mr) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
      end
   end

   // Running wrap count, free to roll over silently.
   always_ff @(posedge i_clk) begin
      if (i_mr) begin
         r_wraps <= '0;
      end else if (w_wrapEvt) begin
         r_wraps <= r_wraps + {{(W-1){1'b0}}, 1'b1};
      end
   end

   // Single-entry holding register. A new measurement is taken whenever the
   // slot is empty or is being drained on this same edge; otherwise it is lost
   // and the loss is remembered until the next MR.
   always_ff @(posedge i_clk) begin
      if (i_mr) begin
         r_period  <= '0;
         r_psat    <= 1'b0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_capture) begin
         if (!r_valid || i_ready) begin
            r_period <= w_cntSat;
            r_psat   <= w_cntAtSat;
            r_valid  <= 1'b1;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (w_handshake) begin
         r_valid <= 1'b0;
      end
   end

   assign o_wraps   = r_wraps;
   assign o_period  = r_period;
   assign o_psat    = r_psat;
   assign o_valid   = r_valid;
   assign o_overrun = r_overrun;
   assign o_armed   = (r_state == ST_ARMED);

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// tb_counter_wrap_monitor
// Directed bench for counter_wrap_monitor. A behavioural 4-bit loadable
// counter lives in the bench and feeds both a default-sized monitor and a
// narrow one (W=2, P=4) from the same nets, so saturation and wrap-count
// roll-over can be exercised alongside the normal-width behaviour.

module tb_counter_wrap_monitor;

   logic       clk;
   logic       mr;
   logic       load;
   logic       en;
   logic [3:0] q;
   logic [3:0] d;
   logic       ready;

   logic [7:0]  wraps;
   logic [11:0] period;
   logic        psat;
   logic        valid;
   logic        overrun;
   logic        armed;

   logic [1:0]  wrapsS;
   logic [3:0]  periodS;
   logic        psatS;
   logic        validS;
   logic        overrunS;
   logic        armedS;

   int checks = 0;
   int errors = 0;
   int expWraps = 0;
   bit lastWrap = 1'b0;
   bit toggleEn = 1'b0;

   counter_wrap_monitor dut (
      .i_clk(clk), .i_mr(mr), .i_load(load), .i_en(en), .i_q(q), .i_ready(ready),
      .o_wraps(wraps), .o_period(period), .o_psat(psat), .o_valid(valid),
      .o_overrun(overrun), .o_armed(armed)
   );

   counter_wrap_monitor #(.W(2), .P(4)) dutSmall (
      .i_clk(clk), .i_mr(mr), .i_load(load), .i_en(en), .i_q(q), .i_ready(ready),
      .o_wraps(wrapsS), .o_period(periodS), .o_psat(psatS), .o_valid(validS),
      .o_overrun(overrunS), .o_armed(armedS)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge: advance the modelled counter and the expected wrap count,
   // leaving outputs settled 1 time unit after the edge for sampling.
   task automatic tick();
      bit w;
      w = load && en && (q == 4'hF);
      @(posedge clk);
      #1;
      lastWrap = w && !mr;
      if (mr) begin
         q        = 4'h0;
         expWraps = 0;
      end else begin
         if (!load) q = d;
         else if (en) q = q + 4'h1;
         if (w) expWraps = expWraps + 1;
      end
      if (toggleEn) en = !en;
   endtask

   // Tick until the modelled counter wraps, with a bounded budget.
   task automatic runToWrap();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         tick();
         if (lastWrap) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL wrap_timeout: no wrap within 200 cycles (q=%0h)", q);
      end
   endtask

   task automatic test_reset();
      mr = 1'b1; load = 1'b1; en = 1'b1; ready = 1'b1; d = 4'h0; q = 4'h0;
      tick();
      tick();
      checks++; if (wraps !== 8'd0) begin errors++; $display("[TB] FAIL reset_wraps: got %0d want 0", wraps); end
      checks++; if (period !== 12'd0) begin errors++; $display("[TB] FAIL reset_period: got %0d want 0", period); end
      checks++; if (psat !== 1'b0) begin errors++; $display("[TB] FAIL reset_psat: got %b want 0", psat); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
      checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL reset_armed: got %b want 0", armed); end
      checks++; if (wrapsS !== 2'd0 || validS !== 1'b0) begin errors++; $display("[TB] FAIL reset_small: got wraps=%0d valid=%b want 0/0", wrapsS, validS); end
   endtask

   task automatic test_first_wraps();
      mr = 1'b0;
      runToWrap();
      checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL first_armed: got %b want 1", armed); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL first_valid: got %b want 0", valid); end
      checks++; if (wraps !== 8'd1) begin errors++; $display("[TB] FAIL first_wraps: got %0d want 1", wraps); end
      runToWrap();
      checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL second_valid: got %b want 1", valid); end
      checks++; if (period !== 12'd16) begin errors++; $display("[TB] FAIL second_period: got %0d want 16", period); end
      checks++; if (psat !== 1'b0) begin errors++; $display("[TB] FAIL second_psat: got %b want 0", psat); end
      checks++; if (wraps !== 8'd2) begin errors++; $display("[TB] FAIL second_wraps: got %0d want 2", wraps); end
      checks++; if (periodS !== 4'd15 || psatS !== 1'b1) begin errors++; $display("[TB] FAIL small_sat: got period=%0d psat=%b want 15/1", periodS, psatS); end
   endtask

   task automatic test_en_toggle();
      toggleEn = 1'b1;
      runToWrap();
      for (int k = 0; k < 2; k++) begin
         runToWrap();
         checks++; if (period !== 12'd32) begin errors++; $display("[TB] FAIL toggle_period[%0d]: got %0d want 32", k, period); end
         checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL toggle_valid[%0d]: got %b want 1", k, valid); end
         checks++; if (wraps !== 8'(expWraps)) begin errors++; $display("[TB] FAIL toggle_wraps[%0d]: got %0d want %0d", k, wraps, 8'(expWraps)); end
      end
      toggleEn = 1'b0;
      en = 1'b1;
   endtask

   task automatic test_overrun();
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid: got %b want 0", valid); end
      ready = 1'b0;
      runToWrap();
      checks++; if (valid !== 1'b1 || period !== 12'd16) begin errors++; $display("[TB] FAIL ovr_first: got valid=%b period=%0d want 1/16", valid, period); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_early: got %b want 0", overrun); end
      runToWrap();
      checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set: got %b want 1", overrun); end
      checks++; if (valid !== 1'b1 || period !== 12'd16) begin errors++; $display("[TB] FAIL ovr_held: got valid=%b period=%0d want 1/16", valid, period); end
      ready = 1'b1;
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_drain: got %b want 0", valid); end
      checks++; if (period !== 12'd16 || overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got period=%0d overrun=%b want 16/1", period, overrun); end
   endtask

   task automatic test_load_break();
      for (int i = 0; i < 5; i++) tick();
      load = 1'b0; d = 4'h5;
      tick();
      load = 1'b1;
      checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL load_armed: got %b want 0", armed); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL load_valid: got %b want 0", valid); end
      runToWrap();
      checks++; if (armed !== 1'b1 || valid !== 1'b0) begin errors++; $display("[TB] FAIL load_rearm: got armed=%b valid=%b want 1/0", armed, valid); end
      runToWrap();
      checks++; if (valid !== 1'b1 || period !== 12'd16) begin errors++; $display("[TB] FAIL load_period: got valid=%b period=%0d want 1/16", valid, period); end
   endtask

   task automatic test_back_to_back();
      mr = 1'b1;
      tick();
      tick();
      mr = 1'b0;
      runToWrap();
      runToWrap();
      checks++; if (validS !== 1'b1 || periodS !== 4'd15 || psatS !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got valid=%b period=%0d psat=%b want 1/15/1", validS, periodS, psatS); end
      ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_hold: got %b want 1", valid); end
      ready = 1'b1;
      tick();
      checks++; if (lastWrap !== 1'b1 || valid !== 1'b1 || validS !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid: got wrap=%b valid=%b validS=%b want 1/1/1", lastWrap, valid, validS); end
      checks++; if (overrun !== 1'b0 || overrunS !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun: got %b/%b want 0/0", overrun, overrunS); end
      checks++; if (periodS !== 4'd15 || psatS !== 1'b1 || period !== 12'd16) begin errors++; $display("[TB] FAIL b2b_period: got small=%0d psat=%b big=%0d want 15/1/16", periodS, psatS, period); end
   endtask

   task automatic test_mr_wrap();
      for (int i = 0; i < 15; i++) tick();
      mr = 1'b1;
      tick();
      mr = 1'b0;
      checks++; if (wraps !== 8'd0 || wrapsS !== 2'd0) begin errors++; $display("[TB] FAIL mr_wraps: got %0d/%0d want 0/0", wraps, wrapsS); end
      checks++; if (valid !== 1'b0 || armed !== 1'b0) begin errors++; $display("[TB] FAIL mr_state: got valid=%b armed=%b want 0/0", valid, armed); end
      for (int k = 0; k < 5; k++) runToWrap();
      checks++; if (wrapsS !== 2'd1) begin errors++; $display("[TB] FAIL small_rollover: got %0d want 1", wrapsS); end
      checks++; if (wraps !== 8'd5) begin errors++; $display("[TB] FAIL big_wraps: got %0d want 5", wraps); end
   endtask

   // Scenario sequence; each step continues from the state the previous one left.
   initial begin
      test_reset();
      test_first_wraps();
      test_en_toggle();
      test_overrun();
      test_load_break();
      test_back_to_back();
      test_mr_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
